// File: rtl/ns_dsp_pkg.sv
// Shared types and sizing helpers for the noise-shaper / CIC receive path.
package ns_dsp_pkg;

  localparam int unsigned CIC_ORDER_DEFAULT  = 5;
  localparam int unsigned DECIM_LOG2_DEFAULT = 6;

  // Bit growth of an N-stage CIC at ratio 2^log2r, plus sign and headroom.
  function automatic int unsigned cic_acc_bits(input int unsigned order,
                                               input int unsigned log2r);
    return order * log2r + 2;
  endfunction

  typedef enum logic [1:0] {CIC_IDLE, CIC_COMB, CIC_OUT} cic_state_t;

endpackage

// File: rtl/cic_integrator_chain.sv
// Strobe-qualified CIC integrator cascade fed by a +/-1 mapped bit stream.
module cic_integrator_chain
  import ns_dsp_pkg::*;
#(
  parameter int unsigned ORDER    = CIC_ORDER_DEFAULT,
  parameter int unsigned ACC_BITS = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en_i,
  input  logic                data_i,
  output logic [ACC_BITS-1:0] acc_next_c
);

  logic [ORDER-1:0][ACC_BITS-1:0] integ_q;
  logic [ORDER-1:0][ACC_BITS-1:0] integ_d;

  // Each stage adds the pre-update value of its predecessor; wrap-around is intended.
  always_comb begin
    integ_d = integ_q;
    if (en_i) begin
      integ_d[0] = integ_q[0] + (data_i ? ACC_BITS'(1) : {ACC_BITS{1'b1}});
      for (int k = 1; k < int'(ORDER); k++) begin
        integ_d[k] = integ_q[k] + integ_q[k-1];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      integ_q <= '0;
    end else begin
      integ_q <= integ_d;
    end
  end

  assign acc_next_c = integ_d[ORDER-1];

endmodule

// File: rtl/cic_decimator_1b.sv
// Sinc^N decimator from a 1-bit 3 MHz stream to signed PCM; combs run serially per output.
module cic_decimator_1b
  import ns_dsp_pkg::*;
#(
  parameter int unsigned CIC_ORDER  = CIC_ORDER_DEFAULT,
  parameter int unsigned DECIM_LOG2 = DECIM_LOG2_DEFAULT,
  parameter int unsigned OUT_BITS   = 24
) (
  input  logic                CLK_24M,
  input  logic                reset,
  input  logic                enable_3M,
  input  logic                data_i,
  input  logic                sync_i,
  output logic [OUT_BITS-1:0] pcm_o,
  output logic                pcm_valid_o,
  output logic                busy_o
);

  localparam int unsigned ACC_BITS = cic_acc_bits(CIC_ORDER, DECIM_LOG2);
  localparam int unsigned SHIFT    = ACC_BITS - OUT_BITS;
  localparam int unsigned STG_BITS = (CIC_ORDER > 1) ? $clog2(CIC_ORDER) : 1;
  localparam logic [DECIM_LOG2-1:0] CNT_LAST = '1;
  localparam logic [STG_BITS-1:0]   STG_LAST = STG_BITS'(CIC_ORDER - 1);

  logic [ACC_BITS-1:0] acc_next_c;
  logic                capture_c;
  logic [ACC_BITS-1:0] diff_c;

  logic [DECIM_LOG2-1:0]              cnt_q,   cnt_d;
  cic_state_t                         state_q, state_d;
  logic [STG_BITS-1:0]                stg_q,   stg_d;
  logic [ACC_BITS-1:0]                v_q,     v_d;
  logic [CIC_ORDER-1:0][ACC_BITS-1:0] dly_q,   dly_d;
  logic [OUT_BITS-1:0]                pcm_q,   pcm_d;
  logic                               valid_q, valid_d;
  logic                               busy_q,  busy_d;

  cic_integrator_chain #(
    .ORDER    (CIC_ORDER),
    .ACC_BITS (ACC_BITS)
  ) u_integ (
    .clk        (CLK_24M),
    .rst        (reset),
    .en_i       (enable_3M),
    .data_i     (data_i),
    .acc_next_c (acc_next_c)
  );

  // A strobe carrying sync_i realigns the phase instead of capturing.
  assign capture_c = enable_3M && !sync_i && (cnt_q == CNT_LAST);
  assign diff_c    = v_q - dly_q[stg_q];

  always_comb begin
    cnt_d   = cnt_q;
    state_d = state_q;
    stg_d   = stg_q;
    v_d     = v_q;
    dly_d   = dly_q;
    pcm_d   = pcm_q;
    valid_d = 1'b0;

    if (sync_i) begin
      cnt_d = '0;
    end else if (enable_3M) begin
      cnt_d = cnt_q + DECIM_LOG2'(1);
    end

    case (state_q)
      CIC_IDLE: begin
        if (capture_c) begin
          v_d     = acc_next_c;
          stg_d   = '0;
          state_d = CIC_COMB;
        end
      end
      CIC_COMB: begin
        dly_d[stg_q] = v_q;
        v_d          = diff_c;
        if (stg_q == STG_LAST) begin
          state_d = CIC_OUT;
        end else begin
          stg_d = stg_q + STG_BITS'(1);
        end
      end
      CIC_OUT: begin
        // Arithmetic shift truncates toward -inf; the result always fits OUT_BITS.
        pcm_d   = OUT_BITS'($signed(v_q) >>> SHIFT);
        valid_d = 1'b1;
        state_d = CIC_IDLE;
      end
      default: state_d = CIC_IDLE;
    endcase

    busy_d = (state_d != CIC_IDLE);
  end

  always_ff @(posedge CLK_24M or posedge reset) begin
    if (reset) begin
      cnt_q   <= '0;
      state_q <= CIC_IDLE;
      stg_q   <= '0;
      v_q     <= '0;
      dly_q   <= '0;
      pcm_q   <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      state_q <= state_d;
      stg_q   <= stg_d;
      v_q     <= v_d;
      dly_q   <= dly_d;
      pcm_q   <= pcm_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
    end
  end

  assign pcm_o       = pcm_q;
  assign pcm_valid_o = valid_q;
  assign busy_o      = busy_q;

endmodule
